// File: rtl/output_driver_pkg.sv
// rtl/output_driver_pkg.sv - shared opcodes, mode codes, field layout and FSM states for the output-driver config sequencer
package output_driver_pkg;

  localparam logic [1:0] OP_SET_MODE    = 2'b00;
  localparam logic [1:0] OP_SET_DELAY   = 2'b01;
  localparam logic [1:0] OP_SET_WIDTH   = 2'b10;
  localparam logic [1:0] OP_SET_PATTERN = 2'b11;

  localparam logic [1:0] M_DISABLED       = 2'd0;
  localparam logic [1:0] M_PULSE          = 2'd1;
  localparam logic [1:0] M_PATTERN_SINGLE = 2'd2;
  localparam logic [1:0] M_PATTERN_LOOP   = 2'd3;

  // op-word layout: opcode in [31:30], info field right-aligned in [29:0]
  localparam int OP_LSB     = 30;
  localparam int INFO_MAX_W = 30;
  localparam int MODE_W     = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_GAP,
    S_WIDTH,
    S_MODE
  } state_e;

  function automatic int info_w(input int coarse_w, input int serdes_w);
    return coarse_w + serdes_w;
  endfunction

endpackage

// File: rtl/output_config_rr_arbiter.sv
// rtl/output_config_rr_arbiter.sv - round-robin grant search starting at a registered rotating pointer
module output_config_rr_arbiter #(
  parameter int NUM_CHANNELS = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_CHANNELS-1:0]         eligible_i,
  input  logic                            advance_i,
  output logic                            any_o,
  output logic [NUM_CHANNELS-1:0]         grant_o,
  output logic [$clog2(NUM_CHANNELS)-1:0] grant_idx_o
);

  localparam int IDX_W = $clog2(NUM_CHANNELS);

  logic [IDX_W-1:0] rr_next_q, rr_next_d;
  logic             found;
  logic [IDX_W-1:0] found_idx;

  always_comb begin
    int cand;
    cand      = 0;
    found     = 1'b0;
    found_idx = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      cand = int'(rr_next_q) + k;
      if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
      if (!found && eligible_i[IDX_W'(cand)]) begin
        found     = 1'b1;
        found_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (found) grant_o[found_idx] = 1'b1;
    rr_next_d = (found_idx == IDX_W'(NUM_CHANNELS - 1)) ? '0 : found_idx + 1'b1;
  end

  assign any_o       = found;
  assign grant_idx_o = found_idx;

  // the pointer only moves when a grant is actually taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_next_q <= '0;
    end else if (advance_i && found) begin
      rr_next_q <= rr_next_d;
    end
  end

endmodule

// File: rtl/output_driver_config_sequencer.sv
// rtl/output_driver_config_sequencer.sv - arbitrates channel config requests and serialises DELAY/WIDTH/MODE op-words
module output_driver_config_sequencer
  import output_driver_pkg::*;
#(
  parameter int NUM_CHANNELS       = 8,
  parameter int SERDES_WIDTH       = 4,
  parameter int COARSE_DELAY_WIDTH = 22,
  parameter int COARSE_WIDTH_WIDTH = 20,
  parameter int GAP_CYCLES         = 2,
  parameter int MODE_HOLDOFF       = 16
) (
  input  logic                                                      sysClk,
  input  logic                                                      sysReset,
  input  logic [NUM_CHANNELS-1:0]                                   reqValid,
  input  logic [NUM_CHANNELS*(COARSE_DELAY_WIDTH+SERDES_WIDTH)-1:0] reqDelayInfo,
  input  logic [NUM_CHANNELS*(COARSE_WIDTH_WIDTH+SERDES_WIDTH)-1:0] reqWidthInfo,
  input  logic [NUM_CHANNELS*2-1:0]                                 reqMode,
  output logic [NUM_CHANNELS-1:0]                                   reqAck,
  output logic [NUM_CHANNELS-1:0]                                   csrStrobe,
  output logic [31:0]                                               gpioOut,
  output logic                                                      busy
);

  localparam int DELAY_INFO_W = info_w(COARSE_DELAY_WIDTH, SERDES_WIDTH);
  localparam int WIDTH_INFO_W = info_w(COARSE_WIDTH_WIDTH, SERDES_WIDTH);
  localparam int IDX_W        = $clog2(NUM_CHANNELS);
  localparam int HOLD_W       = $clog2(MODE_HOLDOFF + 1);
  localparam int GAP_W        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e                  state_q, state_d;
  state_e                  ret_q, ret_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [DELAY_INFO_W-1:0] delay_q, delay_d;
  logic [WIDTH_INFO_W-1:0] width_q, width_d;
  logic [MODE_W-1:0]       mode_q, mode_d;
  logic [NUM_CHANNELS-1:0] strobe_q, strobe_d;
  logic [NUM_CHANNELS-1:0] ack_q, ack_d;
  logic [31:0]             gpio_q, gpio_d;
  logic                    busy_q, busy_d;
  logic [HOLD_W-1:0]       holdoff_q [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] eligible;
  logic                    arb_any;
  logic [NUM_CHANNELS-1:0] arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    word_done;
  state_e                  after_word;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = reqValid[i] && (holdoff_q[i] == '0);
    end
  end

  output_config_rr_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_arb (
    .clk_i      (sysClk),
    .rst_i      (sysReset),
    .eligible_i (eligible),
    .advance_i  (state_q == S_IDLE),
    .any_o      (arb_any),
    .grant_o    (arb_grant),
    .grant_idx_o(arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    gap_d      = gap_q;
    grant_d    = grant_q;
    delay_d    = delay_q;
    width_d    = width_q;
    mode_d     = mode_q;
    word_done  = 1'b0;
    after_word = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          state_d = S_DELAY;
          grant_d = arb_idx;
          delay_d = reqDelayInfo[arb_idx*DELAY_INFO_W +: DELAY_INFO_W];
          width_d = reqWidthInfo[arb_idx*WIDTH_INFO_W +: WIDTH_INFO_W];
          mode_d  = reqMode[arb_idx*MODE_W +: MODE_W];
        end
      end
      S_DELAY: begin word_done = 1'b1; after_word = S_WIDTH; end
      S_WIDTH: begin word_done = 1'b1; after_word = S_MODE;  end
      S_MODE:  begin word_done = 1'b1; after_word = S_IDLE;  end
      S_GAP: begin
        if (gap_q == '0) state_d = ret_q;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (word_done) begin
      if (GAP_CYCLES == 0) begin
        state_d = after_word;
      end else begin
        state_d = S_GAP;
        ret_d   = after_word;
        gap_d   = GAP_W'(GAP_CYCLES - 1);
      end
    end

    // outputs are decoded from the next state so they register in the same cycle the state is entered
    strobe_d = '0;
    ack_d    = '0;
    gpio_d   = '0;
    case (state_d)
      S_DELAY: gpio_d = {OP_SET_DELAY, 30'(delay_d)};
      S_WIDTH: gpio_d = {OP_SET_WIDTH, 30'(width_d)};
      S_MODE:  gpio_d = {OP_SET_MODE, 28'b0, mode_d};
      default: gpio_d = '0;
    endcase
    if (state_d inside {S_DELAY, S_WIDTH, S_MODE}) strobe_d[grant_d] = 1'b1;
    if (state_d == S_MODE) ack_d[grant_d] = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      gap_q    <= '0;
      grant_q  <= '0;
      delay_q  <= '0;
      width_q  <= '0;
      mode_q   <= '0;
      strobe_q <= '0;
      ack_q    <= '0;
      gpio_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      gap_q    <= gap_d;
      grant_q  <= grant_d;
      delay_q  <= delay_d;
      width_q  <= width_d;
      mode_q   <= mode_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
      gpio_q   <= gpio_d;
      busy_q   <= busy_d;
    end
  end

  // reload wins over decrement so a fresh MODE write always gets the full holdoff
  always_ff @(posedge sysClk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (sysReset) begin
        holdoff_q[i] <= '0;
      end else if (state_q == S_MODE && grant_q == IDX_W'(i)) begin
        holdoff_q[i] <= HOLD_W'(MODE_HOLDOFF);
      end else if (holdoff_q[i] != '0) begin
        holdoff_q[i] <= holdoff_q[i] - 1'b1;
      end
    end
  end

  assign csrStrobe = strobe_q;
  assign reqAck    = ack_q;
  assign gpioOut   = gpio_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_output_driver_config_sequencer.sv
// tb/tb_output_driver_config_sequencer.sv - directed vector bench for the output-driver config sequencer
module tb_output_driver_config_sequencer;

  localparam int N  = 8;
  localparam int DW = 26;
  localparam int WW = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_delay = '0;
  logic [N*WW-1:0] req_width = '0;
  logic [N*2-1:0]  req_mode  = '0;

  logic [N-1:0] ack2, strobe2, ack0, strobe0;
  logic [31:0]  gpio2, gpio0;
  logic         busy2, busy0;

  always #5 clk = ~clk;

  output_driver_config_sequencer #(
    .NUM_CHANNELS(N), .SERDES_WIDTH(4), .COARSE_DELAY_WIDTH(22),
    .COARSE_WIDTH_WIDTH(20), .GAP_CYCLES(2), .MODE_HOLDOFF(16)
  ) dut_g2 (
    .sysClk(clk), .sysReset(rst), .reqValid(req_valid), .reqDelayInfo(req_delay),
    .reqWidthInfo(req_width), .reqMode(req_mode), .reqAck(ack2),
    .csrStrobe(strobe2), .gpioOut(gpio2), .busy(busy2)
  );

  output_driver_config_sequencer #(
    .NUM_CHANNELS(N), .SERDES_WIDTH(4), .COARSE_DELAY_WIDTH(22),
    .COARSE_WIDTH_WIDTH(20), .GAP_CYCLES(0), .MODE_HOLDOFF(16)
  ) dut_g0 (
    .sysClk(clk), .sysReset(rst), .reqValid(req_valid), .reqDelayInfo(req_delay),
    .reqWidthInfo(req_width), .reqMode(req_mode), .reqAck(ack0),
    .csrStrobe(strobe0), .gpioOut(gpio0), .busy(busy0)
  );

  typedef struct {
    logic [7:0]  valid;
    logic [25:0] dly;
    logic [23:0] wid;
    logic [1:0]  mode;
    logic [7:0]  e_strobe;
    logic [31:0] e_gpio;
    logic [7:0]  e_ack;
    logic        e_busy;
  } vec_t;

  vec_t        vecs [11];
  int          total = 0;
  int          bad   = 0;
  int          order [6];
  int          exp_order [6];
  int          n_ack, n_str, ch, mode_cyc, redelay_cyc;
  logic        found;
  logic [31:0] words [3];
  logic [25:0] rr_d [N];
  logic [1:0]  rr_m [N];
  logic [7:0]  g0_strobe [8];
  logic [31:0] g0_gpio [8];
  logic [7:0]  g0_ack [8];
  logic        g0_busy [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [25:0] d, input logic [23:0] w, input logic [1:0] m);
    req_delay[c*DW +: DW] = d;
    req_width[c*WW +: WW] = w;
    req_mode[c*2 +: 2]    = m;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic int oh2i(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ch3 single request; data changes one cycle after grant must not leak into WIDTH/MODE
    vecs[0]  = '{8'h08, 26'h1234567, 24'h0ABCDE, 2'd1, 8'h08, 32'h41234567, 8'h00, 1'b1};
    vecs[1]  = '{8'h08, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h00, 32'h00000000, 8'h00, 1'b1};
    vecs[2]  = '{8'h08, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h00, 32'h00000000, 8'h00, 1'b1};
    vecs[3]  = '{8'h08, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h08, 32'h800ABCDE, 8'h00, 1'b1};
    vecs[4]  = '{8'h08, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h00, 32'h00000000, 8'h00, 1'b1};
    vecs[5]  = '{8'h08, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h00, 32'h00000000, 8'h00, 1'b1};
    vecs[6]  = '{8'h08, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h08, 32'h00000001, 8'h08, 1'b1};
    vecs[7]  = '{8'h00, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h00, 32'h00000000, 8'h00, 1'b1};
    vecs[8]  = '{8'h00, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h00, 32'h00000000, 8'h00, 1'b1};
    vecs[9]  = '{8'h00, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h00, 32'h00000000, 8'h00, 1'b0};
    vecs[10] = '{8'h00, 26'h2AAAAAA, 24'h555555, 2'd3, 8'h00, 32'h00000000, 8'h00, 1'b0};

    do_reset();
    chk("reset_strobe_g2", strobe2, 0);
    chk("reset_gpio_g2",   gpio2,   0);
    chk("reset_ack_g2",    ack2,    0);
    chk("reset_busy_g2",   busy2,   0);
    chk("reset_strobe_g0", strobe0, 0);
    chk("reset_gpio_g0",   gpio0,   0);
    chk("reset_ack_g0",    ack0,    0);
    chk("reset_busy_g0",   busy0,   0);

    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].valid;
      set_ch(3, vecs[i].dly, vecs[i].wid, vecs[i].mode);
      step();
      chk($sformatf("vec%0d_strobe", i), strobe2, vecs[i].e_strobe);
      chk($sformatf("vec%0d_gpio", i),   gpio2,   vecs[i].e_gpio);
      chk($sformatf("vec%0d_ack", i),    ack2,    vecs[i].e_ack);
      chk($sformatf("vec%0d_busy", i),   busy2,   vecs[i].e_busy);
    end

    // round robin across channels 0, 2, 5 requesting continuously
    do_reset();
    rr_d[0] = 26'h0000011; rr_m[0] = 2'd1; set_ch(0, rr_d[0], 24'h000021, rr_m[0]);
    rr_d[2] = 26'h0000012; rr_m[2] = 2'd2; set_ch(2, rr_d[2], 24'h000022, rr_m[2]);
    rr_d[5] = 26'h0000015; rr_m[5] = 2'd3; set_ch(5, rr_d[5], 24'h000025, rr_m[5]);
    exp_order[0] = 0; exp_order[1] = 2; exp_order[2] = 5;
    exp_order[3] = 0; exp_order[4] = 2; exp_order[5] = 5;
    req_valid = 8'h25;
    n_ack = 0;
    for (int c = 0; c < 200 && n_ack < 6; c++) begin
      step();
      if (strobe2 != 0) begin
        ch = oh2i(strobe2);
        if (gpio2[31:30] == 2'b01) chk("rr_delay_word", gpio2, {2'b01, 4'b0, rr_d[ch]});
        if (ack2 != 0) begin
          chk("rr_ack_on_strobe", ack2, strobe2);
          chk("rr_mode_word", gpio2, {30'b0, rr_m[ch]});
          order[n_ack] = ch;
          n_ack++;
        end
      end
    end
    chk("rr_ack_count", n_ack, 6);
    for (int i = 0; i < n_ack; i++) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);

    // ch1 re-requests immediately: holdoff must space its next DELAY from its MODE
    do_reset();
    set_ch(1, 26'h0000101, 24'h000201, 2'd1);
    req_valid   = 8'h02;
    mode_cyc    = -1;
    redelay_cyc = -1;
    for (int c = 0; c < 100 && redelay_cyc < 0; c++) begin
      step();
      if (mode_cyc < 0 && ack0[1]) mode_cyc = c;
      else if (mode_cyc >= 0 && strobe0[1] && gpio0[31:30] == 2'b01) redelay_cyc = c;
    end
    chk("hold_redelay_seen", redelay_cyc >= 0, 1);
    chk("hold_min16", (redelay_cyc - mode_cyc) >= 16, 1);
    chk("hold_max20", (redelay_cyc - mode_cyc) <= 20, 1);

    // reset the cycle after WIDTH: sequence abandoned, then fully reissued
    do_reset();
    set_ch(3, 26'h1234567, 24'h0ABCDE, 2'd1);
    req_valid = 8'h08;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (strobe2[3] && gpio2[31:30] == 2'b10) found = 1'b1;
    end
    chk("rst_width_seen", found, 1);
    rst = 1'b1;
    step();
    chk("rst_strobe", strobe2, 0);
    chk("rst_gpio",   gpio2,   0);
    chk("rst_ack",    ack2,    0);
    chk("rst_busy",   busy2,   0);
    rst = 1'b0;
    n_str = 0;
    n_ack = 0;
    for (int i = 0; i < 3; i++) words[i] = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (strobe2 != 0) begin
        chk("rst_reissue_ch", strobe2, 8'h08);
        if (n_str < 3) words[n_str] = gpio2;
        n_str++;
      end
      if (ack2 != 0) begin
        chk("rst_ack_ch", ack2, 8'h08);
        chk("rst_ack_with_mode", gpio2, 32'h00000001);
        n_ack++;
        req_valid = '0;
      end
    end
    chk("rst_strobe_count", n_str, 3);
    chk("rst_word0", words[0], 32'h41234567);
    chk("rst_word1", words[1], 32'h800ABCDE);
    chk("rst_word2", words[2], 32'h00000001);
    chk("rst_ack_count", n_ack, 1);

    // zero gap: three consecutive strobes, max-width fields, gpio idle at zero
    do_reset();
    set_ch(6, 26'h3FFFFFF, 24'hFFFFFF, 2'd2);
    req_valid = 8'h40;
    for (int c = 0; c < 8; c++) begin
      step();
      g0_strobe[c] = strobe0;
      g0_gpio[c]   = gpio0;
      g0_ack[c]    = ack0;
      g0_busy[c]   = busy0;
      if (strobe0 == 0) chk($sformatf("g0_idle_zero%0d", c), gpio0, 0);
      if (ack0 != 0) req_valid = '0;
    end
    chk("g0_delay_strobe", g0_strobe[0], 8'h40);
    chk("g0_delay_word",   g0_gpio[0],   32'h43FFFFFF);
    chk("g0_busy0",        g0_busy[0],   1);
    chk("g0_width_strobe", g0_strobe[1], 8'h40);
    chk("g0_width_word",   g0_gpio[1],   32'h80FFFFFF);
    chk("g0_mode_strobe",  g0_strobe[2], 8'h40);
    chk("g0_mode_word",    g0_gpio[2],   32'h00000002);
    chk("g0_mode_ack",     g0_ack[2],    8'h40);
    chk("g0_after_strobe", g0_strobe[3], 0);
    chk("g0_after_ack",    g0_ack[3],    0);
    chk("g0_after_busy",   g0_busy[3],   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
